// File: rtl/mpeg2_pkg.sv
// rtl/mpeg2_pkg.sv - MPEG-2 scan tables, saturation limits and iquant_scan state encoding
package mpeg2_pkg;

    // Scan position -> raster index (row*8 + column)
    localparam int ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam int ALT_SCAN [64] = '{
         0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
        41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
        51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
        53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63
    };

    localparam int SAT_MIN = -2048;
    localparam int SAT_MAX = 2047;
    localparam int SAT_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_MISMATCH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/scan_rom.sv
// rtl/scan_rom.sv - combinational inverse scan: scan position to raster index
module scan_rom
    import mpeg2_pkg::*;
(
    input  logic [5:0] pos,
    input  logic       alt,
    output logic [5:0] raster
);

    assign raster = alt ? 6'(ALT_SCAN[pos]) : 6'(ZIGZAG[pos]);

endmodule

// File: rtl/iquant_scan.sv
// rtl/iquant_scan.sv - token inverse scan, inverse quantisation, saturation and mismatch control into block RAM
module iquant_scan
    import mpeg2_pkg::*;
#(
    parameter int LEVEL_W = 12,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    output logic                      rdy,
    input  logic                      intra,
    input  logic                      alt_scan,
    input  logic [6:0]                qscale,
    input  logic [3:0]                dc_mult,
    input  logic                      coef_valid,
    output logic                      coef_ready,
    input  logic [5:0]                coef_run,
    input  logic signed [LEVEL_W-1:0] coef_level,
    input  logic                      coef_eob,
    output logic [5:0]                qm_addr,
    input  logic [7:0]                qm_q,
    output logic [5:0]                addr,
    output logic                      wren,
    output logic [DATA_W-1:0]         data,
    output logic                      done,
    output logic                      err
);

    state_e state, state_n;

    logic [5:0]  clr_cnt;
    logic        intra_r, alt_r;
    logic [6:0]  qscale_r;
    logic [3:0]  dc_r;
    logic [6:0]  pos;
    logic        first;
    logic        parity;
    logic [DATA_W-1:0] val63;

    logic                      p_valid, p_dc;
    logic [5:0]                p_addr;
    logic signed [LEVEL_W-1:0] p_level;

    logic        accept, tok, pos_ok;
    logic [7:0]  pos_sum;
    logic [6:0]  pos_next;
    logic [5:0]  raster;

    logic signed [31:0] lvl_ext, k_val, prod, quot, dc_prod, f_full;
    logic signed [SAT_W-1:0] f_sat;
    logic [DATA_W-1:0]  data_w;

    assign accept = coef_valid && (state == ST_RUN);
    assign tok    = accept && !coef_eob;

    // Positions stick at 127 once past the block so later tokens stay out of range
    assign pos_sum  = {1'b0, pos} + {2'b00, coef_run} + 8'd1;
    assign pos_next = first ? {1'b0, coef_run} : ((pos_sum > 8'd127) ? 7'd127 : pos_sum[6:0]);
    assign pos_ok   = (pos_next < 7'd64);

    scan_rom u_scan (
        .pos    (pos_next[5:0]),
        .alt    (alt_r),
        .raster (raster)
    );

    assign qm_addr = (tok && pos_ok) ? raster : 6'd0;

    // Second stage: W arrives from the ROM one cycle after the address was issued
    always_comb begin
        lvl_ext = {{(32-LEVEL_W){p_level[LEVEL_W-1]}}, p_level};
        k_val   = 32'sd0;
        if (!intra_r) begin
            if (lvl_ext > 0)
                k_val = 32'sd1;
            else if (lvl_ext < 0)
                k_val = -32'sd1;
        end
        prod    = ((lvl_ext <<< 1) + k_val) * $signed({24'd0, qm_q}) * $signed({25'd0, qscale_r});
        quot    = (prod + (prod[31] ? 32'sd31 : 32'sd0)) >>> 5;
        dc_prod = lvl_ext * $signed({28'd0, dc_r});
        f_full  = p_dc ? dc_prod : quot;
        if (f_full > SAT_MAX)
            f_sat = SAT_W'(SAT_MAX);
        else if (f_full < SAT_MIN)
            f_sat = SAT_W'(SAT_MIN);
        else
            f_sat = f_full[SAT_W-1:0];
        data_w = {{(DATA_W-SAT_W){f_sat[SAT_W-1]}}, f_sat};
    end

    always_comb begin
        state_n    = state;
        rdy        = 1'b0;
        coef_ready = 1'b0;
        wren       = 1'b0;
        addr       = 6'd0;
        data       = '0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en)
                    state_n = ST_CLEAR;
            end
            ST_CLEAR: begin
                wren = 1'b1;
                addr = clr_cnt;
                if (clr_cnt == 6'd63)
                    state_n = ST_RUN;
            end
            ST_RUN: begin
                coef_ready = 1'b1;
                if (p_valid) begin
                    wren = 1'b1;
                    addr = p_addr;
                    data = data_w;
                end
                if (accept && coef_eob)
                    state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_n = ST_MISMATCH;
            end
            ST_MISMATCH: begin
                // Even coefficient sum: toggle the LSB of the last coefficient
                if (!parity) begin
                    wren = 1'b1;
                    addr = 6'd63;
                    data = val63 ^ {{(DATA_W-1){1'b0}}, 1'b1};
                end
                state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            clr_cnt  <= 6'd0;
            intra_r  <= 1'b0;
            alt_r    <= 1'b0;
            qscale_r <= 7'd0;
            dc_r     <= 4'd0;
            pos      <= 7'd0;
            first    <= 1'b1;
            parity   <= 1'b0;
            val63    <= '0;
            err      <= 1'b0;
            p_valid  <= 1'b0;
            p_dc     <= 1'b0;
            p_addr   <= 6'd0;
            p_level  <= '0;
        end else begin
            state   <= state_n;
            p_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        intra_r  <= intra;
                        alt_r    <= alt_scan;
                        qscale_r <= qscale;
                        dc_r     <= dc_mult;
                        clr_cnt  <= 6'd0;
                        pos      <= 7'd0;
                        first    <= 1'b1;
                        parity   <= 1'b0;
                        val63    <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 6'd1;
                end
                ST_RUN: begin
                    if (tok) begin
                        first <= 1'b0;
                        pos   <= pos_next;
                        if (pos_ok) begin
                            p_valid <= 1'b1;
                            p_addr  <= raster;
                            p_level <= coef_level;
                            p_dc    <= intra_r && (pos_next == 7'd0);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (p_valid) begin
                        parity <= parity ^ f_sat[0];
                        if (p_addr == 6'd63)
                            val63 <= data_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iquant_scan.sv
// tb/tb_iquant_scan.sv - scoreboard bench for iquant_scan with RAM and quant-matrix ROM models
module tb_iquant_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, intra, alt_scan, coef_valid, coef_eob;
    logic [6:0]  qscale;
    logic [3:0]  dc_mult;
    logic [5:0]  coef_run;
    logic [11:0] coef_level;
    logic        rdy, coef_ready, wren, done, err;
    logic [5:0]  qm_addr, addr;
    logic [7:0]  qm_q;
    logic [15:0] data;

    typedef struct {
        logic [5:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          tr[$];
    int          tl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          w_const  = 16;
    int          clr_seen = 0;
    int          clr_bad  = 0;
    logic [15:0] mem [64];
    logic [15:0] img [64];

    int zz_t [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    int alt_t [64] = '{
         0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
        41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
        51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
        53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63
    };

    iquant_scan dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rdy        (rdy),
        .intra      (intra),
        .alt_scan   (alt_scan),
        .qscale     (qscale),
        .dc_mult    (dc_mult),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_run   (coef_run),
        .coef_level (coef_level),
        .coef_eob   (coef_eob),
        .qm_addr    (qm_addr),
        .qm_q       (qm_q),
        .addr       (addr),
        .wren       (wren),
        .data       (data),
        .done       (done),
        .err        (err)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, expv, $time);
        end
    endtask

    function automatic int wfun(int r);
        return (w_const != 0) ? w_const : ((r * 37 + 11) % 256);
    endfunction

    function automatic int f_model(bit intr, int p, int qf, int w, int qs, int dc);
        int k, f;
        if (intr && p == 0) begin
            f = dc * qf;
        end else begin
            k = intr ? 0 : ((qf > 0) ? 1 : ((qf < 0) ? -1 : 0));
            f = ((2 * qf + k) * w * qs) / 32;
        end
        if (f > 2047) f = 2047;
        if (f < -2048) f = -2048;
        return f;
    endfunction

    always @(posedge clk) qm_q <= 8'(wfun(int'(qm_addr)));

    // RAM model and write scoreboard
    always @(negedge clk) begin
        if (reset) begin
            clr_seen = 0;
        end else begin
            if (rdy && en) begin
                clr_seen = 0;
                clr_bad  = 0;
                for (int i = 0; i < 64; i++) mem[i] = 16'hA5A5;
            end
            if (wren) begin
                mem[addr] = data;
                if (clr_seen < 64) begin
                    if (addr != 6'(clr_seen) || data != 16'd0) clr_bad++;
                    clr_seen++;
                end else begin
                    chk("wr_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        wr_t w;
                        w = exp_q.pop_front();
                        chk("wr_addr", {26'd0, addr}, {26'd0, w.a});
                        chk("wr_data", {16'd0, data}, {16'd0, w.d});
                    end
                end
            end
        end
    end

    task automatic start(bit intr, bit alt, int qs, int dc);
        int n = 0;
        while (!rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", 32'(rdy), 1);
        intra = intr; alt_scan = alt; qscale = 7'(qs); dc_mult = 4'(dc); en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        intra = ~intr; alt_scan = ~alt; qscale = 7'd0; dc_mult = 4'd0;
    endtask

    task automatic send(int run, int lvl, bit eob);
        int n = 0;
        bit acc = 1'b0;
        coef_valid = 1'b1; coef_run = 6'(run); coef_level = 12'(lvl); coef_eob = eob;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = coef_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("tok_accept", 32'(acc), 1);
        coef_valid = 1'b0; coef_eob = 1'b0;
    endtask

    task automatic run_block(bit intr, bit alt, int qs, int dc, int wc);
        int  pos = 0, p, r, f, n = 0, v63 = 0;
        bit  first = 1'b1, e_err = 1'b0, par = 1'b0;
        wr_t w;
        w_const = wc;
        for (int i = 0; i < 64; i++) img[i] = 16'd0;
        foreach (tr[i]) begin
            p = first ? tr[i] : pos + tr[i] + 1;
            first = 1'b0;
            pos = p;
            if (p > 63) begin
                e_err = 1'b1;
            end else begin
                r = alt ? alt_t[p] : zz_t[p];
                f = f_model(intr, p, tl[i], wfun(r), qs, dc);
                img[r] = f[15:0];
                par ^= f[0];
                if (r == 63) v63 = f;
                w.a = 6'(r); w.d = f[15:0];
                exp_q.push_back(w);
            end
        end
        if (!par) begin
            v63 = v63 ^ 1;
            img[63] = v63[15:0];
            w.a = 6'd63; w.d = v63[15:0];
            exp_q.push_back(w);
        end
        start(intr, alt, qs, dc);
        foreach (tr[i]) send(tr[i], tl[i], 1'b0);
        send(0, 0, 1'b1);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        chk("err", 32'(err), 32'(e_err));
        chk("clear_cnt", clr_seen, 64);
        chk("clear_bad", clr_bad, 0);
        chk("queue_left", exp_q.size(), 0);
        for (int i = 0; i < 64; i++)
            chk($sformatf("ram%0d", i), {16'd0, mem[i]}, {16'd0, img[i]});
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("rdy_after", 32'(rdy), 1);
        exp_q.delete(); tr.delete(); tl.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b0; intra = 1'b0; alt_scan = 1'b0; qscale = 7'd1; dc_mult = 4'd1;
        coef_valid = 1'b0; coef_run = 6'd0; coef_level = 12'd0; coef_eob = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy), 1);
        chk("rst_coef_ready", 32'(coef_ready), 0);
        chk("rst_wren", 32'(wren), 0);
        chk("rst_data", {16'd0, data}, 0);
        chk("rst_addr", {26'd0, addr}, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;

        tr = '{0}; tl = '{16};
        run_block(1'b1, 1'b0, 5, 8, 16);
        tr = '{0}; tl = '{1};
        run_block(1'b0, 1'b0, 2, 1, 16);
        tr = '{0}; tl = '{-1};
        run_block(1'b0, 1'b0, 2, 1, 16);
        tr = '{0}; tl = '{-1};
        run_block(1'b0, 1'b0, 1, 1, 16);
        tr = '{0}; tl = '{2047};
        run_block(1'b0, 1'b0, 112, 1, 255);
        tr = '{3}; tl = '{-2048};
        run_block(1'b0, 1'b1, 112, 1, 255);
        tr = '{1}; tl = '{5};
        run_block(1'b0, 1'b0, 1, 1, 16);
        tr = '{1}; tl = '{5};
        run_block(1'b0, 1'b1, 1, 1, 16);
        tr = '{63, 0}; tl = '{1, 1};
        run_block(1'b0, 1'b0, 2, 1, 16);
        run_block(1'b0, 1'b0, 2, 1, 16);
        tr = '{0, 2, 0, 5}; tl = '{-5, 7, 300, -9};
        run_block(1'b1, 1'b0, 9, 2, 0);

        for (int b = 0; b < 4; b++) begin
            int np;
            np = $urandom_range(1, 12);
            for (int t = 0; t < np; t++) begin
                tr.push_back($urandom_range(0, 8));
                tl.push_back(int'($urandom_range(0, 4000)) - 2000);
            end
            run_block(b[0], 1'($urandom_range(0, 1)), $urandom_range(1, 112), 1 << $urandom_range(0, 3), 0);
        end

        // Abort in the middle of CLEAR, then a full block must still work
        start(1'b0, 1'b0, 3, 1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_wren", 32'(wren), 0);
        chk("abort_rdy", 32'(rdy), 1);
        reset = 1'b0;
        tr = '{0, 0, 4}; tl = '{3, -2, 11};
        run_block(1'b0, 1'b0, 3, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
